// File: rtl/hog_gradient_pipe.sv
`default_nettype none
// ============================================================================
// Module   : hog_gradient_pipe
// Purpose  : Two-stage gradient unit for the HOG front end. Accepts one 3x3
//            unsigned pixel window per valid/ready handshake and produces the
//            signed x/y gradients (central difference or Sobel, chosen per
//            window) plus the L1 magnitude |Gx|+|Gy| for the binning stage.
//
// Ports    : clk        clock
//            rst        asynchronous active-high reset
//            k_valid    window valid
//            k_ready    unit can accept a window this cycle
//            kernel     3x3 window, p(r,c) at [(3r+c)*PIXEL_WIDTH +: PIXEL_WIDTH]
//            k_mode     0 = central difference, 1 = Sobel (sampled with kernel)
//            k_border   window straddles the image border -> zero gradients
//            out_valid  result valid
//            out_ready  downstream accepts result
//            Gx, Gy     signed gradients (right-left, top-bottom)
//            mag        unsigned |Gx|+|Gy|
//
// Revision : 1.0 - initial release
// ============================================================================
module hog_gradient_pipe #(
    parameter  int PIXEL_WIDTH  = 8,
    localparam int KERNEL_WIDTH = 9 * PIXEL_WIDTH,
    localparam int G_WIDTH      = PIXEL_WIDTH + 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      k_valid,
    output logic                      k_ready,
    input  logic [KERNEL_WIDTH-1:0]   kernel,
    input  logic                      k_mode,
    input  logic                      k_border,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [G_WIDTH-1:0] Gx,
    output logic signed [G_WIDTH-1:0] Gy,
    output logic [G_WIDTH-1:0]        mag
);

    localparam logic signed [G_WIDTH-1:0] c_G_ZERO   = '0;
    localparam logic [G_WIDTH-1:0]        c_MAG_ZERO = '0;

    // ------------------------------------------------------------------------
    // Window unpacking: every pixel zero-extended to the gradient width so the
    // signed arithmetic below never sees a pixel as negative. Three extra bits
    // cover the worst case of +/-4*(2^PIXEL_WIDTH-1).
    // ------------------------------------------------------------------------
    logic signed [G_WIDTH-1:0] w_pix [9];

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_pix
            assign w_pix[gi] = $signed({{(G_WIDTH-PIXEL_WIDTH){1'b0}},
                                        kernel[gi*PIXEL_WIDTH +: PIXEL_WIDTH]});
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Gradient kernels (pixel index = 3*row + col)
    //   central : Gx = p(1,2)-p(1,0)          Gy = p(0,1)-p(2,1)
    //   Sobel   : weighted 1-2-1 columns/rows
    // ------------------------------------------------------------------------
    logic signed [G_WIDTH-1:0] w_cd_gx;
    logic signed [G_WIDTH-1:0] w_cd_gy;
    logic signed [G_WIDTH-1:0] w_sb_right;
    logic signed [G_WIDTH-1:0] w_sb_left;
    logic signed [G_WIDTH-1:0] w_sb_top;
    logic signed [G_WIDTH-1:0] w_sb_bottom;
    logic signed [G_WIDTH-1:0] w_sb_gx;
    logic signed [G_WIDTH-1:0] w_sb_gy;
    logic signed [G_WIDTH-1:0] w_new_gx;
    logic signed [G_WIDTH-1:0] w_new_gy;

    assign w_cd_gx     = w_pix[5] - w_pix[3];
    assign w_cd_gy     = w_pix[1] - w_pix[7];

    assign w_sb_right  = w_pix[2] + (w_pix[5] <<< 1) + w_pix[8];
    assign w_sb_left   = w_pix[0] + (w_pix[3] <<< 1) + w_pix[6];
    assign w_sb_top    = w_pix[0] + (w_pix[1] <<< 1) + w_pix[2];
    assign w_sb_bottom = w_pix[6] + (w_pix[7] <<< 1) + w_pix[8];

    assign w_sb_gx     = w_sb_right - w_sb_left;
    assign w_sb_gy     = w_sb_top   - w_sb_bottom;

    // Border windows still produce a (zero) result so that the downstream
    // cell accounting stays aligned with the pixel stream.
    always_comb begin
        w_new_gx = c_G_ZERO;
        w_new_gy = c_G_ZERO;
        if (!k_border) begin
            if (k_mode) begin
                w_new_gx = w_sb_gx;
                w_new_gy = w_sb_gy;
            end else begin
                w_new_gx = w_cd_gx;
                w_new_gy = w_cd_gy;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pipeline control. The output stage moves whenever it is empty or being
    // drained; stage 1 moves whenever it is empty or the output stage moves.
    // k_ready depends only on state and out_ready, never on k_valid.
    // ------------------------------------------------------------------------
    logic r_s1_valid;
    logic r_out_valid;
    logic w_s2_load;
    logic w_s1_load;
    logic w_in_xfer;

    assign w_s2_load = !r_out_valid || out_ready;
    assign w_s1_load = !r_s1_valid  || w_s2_load;
    assign k_ready   = w_s1_load;
    assign w_in_xfer = k_valid && w_s1_load;

    // ------------------------------------------------------------------------
    // Stage 1: registered gradients
    // ------------------------------------------------------------------------
    logic signed [G_WIDTH-1:0] r_s1_gx;
    logic signed [G_WIDTH-1:0] r_s1_gy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_gx    <= c_G_ZERO;
            r_s1_gy    <= c_G_ZERO;
        end else begin
            if (w_in_xfer) begin
                r_s1_valid <= 1'b1;
                r_s1_gx    <= w_new_gx;
                r_s1_gy    <= w_new_gy;
            end else if (w_s2_load) begin
                // Stage 1 content (if any) has moved on with nothing behind it.
                r_s1_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: output registers and L1 magnitude.
    // |x| of the most negative G_WIDTH value cannot occur: gradients are
    // bounded by 4*(2^PIXEL_WIDTH-1), and the magnitude sum is bounded by
    // 8*(2^PIXEL_WIDTH-1) which fits the unsigned G_WIDTH result.
    // ------------------------------------------------------------------------
    logic [G_WIDTH-1:0] w_abs_gx;
    logic [G_WIDTH-1:0] w_abs_gy;
    logic [G_WIDTH-1:0] w_mag;

    assign w_abs_gx = r_s1_gx[G_WIDTH-1] ? G_WIDTH'(-r_s1_gx) : G_WIDTH'(r_s1_gx);
    assign w_abs_gy = r_s1_gy[G_WIDTH-1] ? G_WIDTH'(-r_s1_gy) : G_WIDTH'(r_s1_gy);
    assign w_mag    = w_abs_gx + w_abs_gy;

    logic signed [G_WIDTH-1:0] r_gx;
    logic signed [G_WIDTH-1:0] r_gy;
    logic [G_WIDTH-1:0]        r_mag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_gx        <= c_G_ZERO;
            r_gy        <= c_G_ZERO;
            r_mag       <= c_MAG_ZERO;
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            // Data only moves with a valid stage-1 entry, so outputs never
            // pick up stale or undefined values.
            if (r_s1_valid) begin
                r_gx  <= r_s1_gx;
                r_gy  <= r_s1_gy;
                r_mag <= w_mag;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign Gx        = r_gx;
    assign Gy        = r_gy;
    assign mag       = r_mag;

endmodule
`default_nettype wire

// File: doc/hog_gradient_pipe.md
Name: hog_gradient_pipe

Overview:
- Parametrised two-stage gradient unit for the HOG front end.
- Accepts one 3x3 pixel window per handshake and computes signed Gx/Gy. The kernel is either central-difference or Sobel, selected per window.
- Also produces the L1 magnitude |Gx|+|Gy| for the downstream binning stage.
- Full valid/ready backpressure: no transfer is lost or duplicated under stalls.

Parameters:
- PIXEL_WIDTH, 8: bits per unsigned pixel.
- KERNEL_WIDTH, 9*PIXEL_WIDTH: window bus width. Localparam; never overridden.
- G_WIDTH, PIXEL_WIDTH+3: signed gradient width and unsigned magnitude width. Localparam.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- k_valid  in  1  window valid.
- k_ready  out  1  unit can accept a window this cycle.
- kernel  in  KERNEL_WIDTH  window. Pixel p(r,c) is at bits [(3r+c)*PIXEL_WIDTH +: PIXEL_WIDTH]; r=0 is the top row, c=0 is the left column.
- k_mode  in  1  0 = central difference, 1 = Sobel. Sampled with kernel.
- k_border  in  1  window straddles the image border; force zero outputs.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- Gx  out  G_WIDTH  signed x gradient (right minus left).
- Gy  out  G_WIDTH  signed y gradient (top minus bottom).
- mag  out  G_WIDTH  unsigned |Gx|+|Gy|.

Behaviour:
- Reset: all stage valids, out_valid, Gx, Gy, mag and internal registers go to 0 immediately. Mid-operation reset discards in-flight data; first output after release requires a new input transfer.
- Transfer rules: input transfer when k_valid && k_ready; output transfer when out_valid && out_ready.
- Stage 1 (s1): registers Gx, Gy.
  - Mode 0: Gx = p(1,2) - p(1,0); Gy = p(0,1) - p(2,1).
  - Mode 1 (Sobel):
    - Gx = (p(0,2) + 2p(1,2) + p(2,2)) - (p(0,0) + 2p(1,0) + p(2,0))
    - Gy = (p(0,0) + 2p(0,1) + p(0,2)) - (p(2,0) + 2p(2,1) + p(2,2))
  - Operands are zero-extended to G_WIDTH before arithmetic. Results are exact two's complement with no saturation (range +/-4*(2^PIXEL_WIDTH-1) fits).
  - k_border = 1 forces Gx = Gy = 0, regardless of pixels and mode. The transfer still produces a valid output.
- Stage 2 (s2 = output registers): Gx and Gy pass through; mag = |Gx|+|Gy| is computed from the s1 values. Max 8*(2^PIXEL_WIDTH-1) fits unsigned G_WIDTH.
- Latency: an accepted window appears on the outputs exactly 2 cycles later when there is no backpressure.
- Pipeline advance:
  - s2 loads when !out_valid || out_ready.
  - s1 loads when !s1_valid || s2 loads.
  - k_ready = !s1_valid || (!out_valid || out_ready). Combinational from out_ready and state; no combinational path from k_valid.
- Valid flags:
  - s1_valid is set on an input transfer and cleared when s1 empties into s2 with no new input.
  - out_valid is set when s2 loads from a valid s1, and cleared on an output transfer if s1 is empty.
- Stall: while out_valid && !out_ready, Gx/Gy/mag/out_valid hold stable. s1 may hold one more window; k_ready then deasserts. Capacity is 2 windows.
- Simultaneous input and output transfer in a full pipe: both occur in the same cycle. Throughput is 1 window/cycle, with no bubble.
- Data registers are never loaded from invalid inputs; values while valid = 0 are don't-care but must not change the outputs while out_valid = 1.

Test Plan:
- Mode 0, PIXEL_WIDTH=8, pixels p(3r+c) = 10*(3r+c), out_ready=1 -> 2 cycles later: Gx=20, Gy=-60, mag=80, out_valid pulse of 1 cycle.
- Mode 1, same window -> Gx=80, Gy=-240, mag=320.
- Mode 1, left column 255, all others 0 -> Gx=-1020, Gy=0, mag=1020. Top row 0, bottom row 255 -> Gy=-1020. Confirms no overflow at G_WIDTH=11.
- k_border=1 with the window of case 1 -> Gx=Gy=mag=0, out_valid asserted.
- Stream 6 back-to-back windows; hold out_ready=0 for 4 cycles after the first output -> k_ready drops after 2 windows held. Outputs are stable during the stall, all 6 results emerge in order with none lost or duplicated, and there is 1 result/cycle after release.
- Assert rst for 1 cycle with 2 windows in flight -> out_valid=0 and outputs 0 immediately; no stale result appears after release; next window returns after 2 cycles.
